// File: rtl/jpeg_pkg.sv
// Shared widths and helpers for the JPEG front-end pixel path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package jpeg_pkg;

    localparam int PIX_W    = 8;
    localparam int ROW_N    = 8;
    localparam int BLK_ROWS = 8;

    // pixel - 128 in two's complement is the pixel with its MSB inverted
    function automatic logic [PIX_W-1:0] level_shift(input logic [PIX_W-1:0] pix);
        return {~pix[PIX_W-1], pix[PIX_W-2:0]};
    endfunction

endpackage

// File: rtl/dct_row_gather_row_bank.sv
// One row buffer: N pixel slots written one at a time, read out in parallel, plus a full flag.
// Latency: a write or a flag change is visible the cycle after the edge that performs it.
// Backpressure: none here; the parent only writes a bank whose full flag is clear.
module row_bank
    import jpeg_pkg::*;
#(
    parameter int N = ROW_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [$clog2(N)-1:0]   i_wr_slot,
    input  logic [PIX_W-1:0]       i_wr_dat,
    input  logic                   i_set_full,
    input  logic                   i_clr_full,
    output logic                   o_full,
    output logic [PIX_W*N-1:0]     o_row
);

    logic [N-1:0][PIX_W-1:0] r_data;
    logic                    r_full;

    // sample storage: one slot written per accepted pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_wr_en) begin
            r_data[i_wr_slot] <= i_wr_dat;
        end
    end

    // full flag: clear wins so a flush always empties the bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
        end else if (i_clr_full) begin
            r_full <= 1'b0;
        end else if (i_set_full) begin
            r_full <= 1'b1;
        end
    end

    assign o_full = r_full;
    assign o_row  = r_data;

endmodule

// File: rtl/dct_row_gather.sv
// Gathers one pixel per clock into N-sample rows (optional -128 level shift) for the DCT row stage.
// Latency: row is presented the cycle after its N-th pixel is accepted.
// Backpressure: ping-pong banks; in_ready drops only when both banks are full, from registered state only.
module dct_row_gather
    import jpeg_pkg::*;
#(
    parameter int N           = ROW_N,
    parameter int ROWS        = BLK_ROWS,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [PIX_W-1:0]     in_pix,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PIX_W*N-1:0]   out_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_row_idx,
    output logic                 out_last
);

    localparam int CW = $clog2(N);

    logic [CW-1:0]      r_wr_cnt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [2:0]         r_row_idx;

    logic [1:0]         w_full;
    logic [PIX_W*N-1:0] w_row0;
    logic [PIX_W*N-1:0] w_row1;
    logic               w_accept;
    logic               w_xfer;
    logic               w_row_done;
    logic [PIX_W-1:0]   w_wr_dat;

    // flush drops any accept or transfer in the same cycle
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_xfer     = out_valid && out_ready && !flush;
    assign w_row_done = w_accept && (r_wr_cnt == CW'(N - 1));
    assign w_wr_dat   = (LEVEL_SHIFT != 0) ? level_shift(in_pix) : in_pix;

    row_bank #(.N(N)) u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept && !r_wr_bank),
        .i_wr_slot  (r_wr_cnt),
        .i_wr_dat   (w_wr_dat),
        .i_set_full (w_row_done && !r_wr_bank),
        .i_clr_full (flush || (w_xfer && !r_rd_bank)),
        .o_full     (w_full[0]),
        .o_row      (w_row0)
    );

    row_bank #(.N(N)) u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept && r_wr_bank),
        .i_wr_slot  (r_wr_cnt),
        .i_wr_dat   (w_wr_dat),
        .i_set_full (w_row_done && r_wr_bank),
        .i_clr_full (flush || (w_xfer && r_rd_bank)),
        .o_full     (w_full[1]),
        .o_row      (w_row1)
    );

    // fill side: slot counter and bank pointer advance per accepted pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (flush) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_accept) begin
            if (w_row_done) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= !r_wr_bank;
            end else begin
                r_wr_cnt  <= r_wr_cnt + 1'b1;
            end
        end
    end

    // drain side: bank pointer and block row index advance per delivered row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_bank <= 1'b0;
            r_row_idx <= '0;
        end else if (flush) begin
            r_rd_bank <= 1'b0;
            r_row_idx <= '0;
        end else if (w_xfer) begin
            r_rd_bank <= !r_rd_bank;
            r_row_idx <= (r_row_idx == 3'(ROWS - 1)) ? 3'd0 : r_row_idx + 3'd1;
        end
    end

    assign in_ready    = !w_full[r_wr_bank];
    assign out_valid   = w_full[r_rd_bank];
    assign out_row     = r_rd_bank ? w_row1 : w_row0;
    assign out_row_idx = r_row_idx;
    assign out_last    = out_valid && (r_row_idx == 3'(ROWS - 1));

endmodule

// File: tb/tb_dct_row_gather.sv
// Scoreboard bench for dct_row_gather: raw instance for most scenarios, level-shift instance for one.
// Latency: expected rows are queued at stimulus time and popped on each output handshake.
// Backpressure: exercised with out_ready held low until both banks fill.
module tb_dct_row_gather;

    typedef struct packed {
        logic [63:0] row;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [7:0]  in_pix;
    logic        in_ready, out_valid, out_last;
    logic [63:0] out_row;
    logic [2:0]  out_row_idx;

    logic        b_flush, b_in_valid, b_out_ready;
    logic [7:0]  b_in_pix;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [63:0] b_out_row;
    logic [2:0]  b_out_row_idx;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        mon_e;
    exp_t        mon_eb;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ls_vec [8];

    always #5 clk = ~clk;

    dct_row_gather #(.N(8), .ROWS(8), .LEVEL_SHIFT(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_pix      (in_pix),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    dct_row_gather #(.N(8), .ROWS(8), .LEVEL_SHIFT(1)) u_dut_ls (
        .clk         (clk),
        .rst         (rst),
        .flush       (b_flush),
        .in_pix      (b_in_pix),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .out_row     (b_out_row),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_row_idx (b_out_row_idx),
        .out_last    (b_out_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] row, input int idx);
        exp_t e;
        e.row  = row;
        e.idx  = idx[2:0];
        e.last = (idx == 7);
        return e;
    endfunction

    // row whose slot k holds base+k
    function automatic logic [63:0] seq_row(input logic [7:0] base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),    64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid),   64'd0);
        chk({tag, "_out_row"},   out_row,          64'd0);
        chk({tag, "_row_idx"},   64'(out_row_idx), 64'd0);
        chk({tag, "_out_last"},  64'(out_last),    64'd0);
    endtask

    // offer one pixel and hold it until the DUT accepts it (bounded)
    task automatic send(input logic [7:0] p);
        int   cnt;
        logic acc;
        cnt      = 0;
        acc      = 1'b0;
        in_pix   = p;
        in_valid = 1'b1;
        while (!acc && cnt < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: pixel %h not accepted, in_ready=%b", p, in_ready);
        end
    endtask

    task automatic wait_drain(input string tag);
        int cnt;
        cnt = 0;
        while (q_a.size() != 0 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_drain_left"}, 64'(q_a.size()), 64'd0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // monitor for the raw instance: every handshake must match the queue head
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_row: got %h idx %0d, no row expected", out_row, out_row_idx);
            end else begin
                mon_e = q_a.pop_front();
                chk("row_data", out_row, mon_e.row);
                chk("row_idx", 64'(out_row_idx), 64'(mon_e.idx));
                chk("row_last", 64'(out_last), 64'(mon_e.last));
            end
        end
    end

    // monitor for the level-shift instance
    always @(negedge clk) begin
        if (rst && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ls_unexpected_row: got %h, no row expected", b_out_row);
            end else begin
                mon_eb = q_b.pop_front();
                chk("ls_row_data", b_out_row, mon_eb.row);
                chk("ls_row_idx", 64'(b_out_row_idx), 64'(mon_eb.idx));
                chk("ls_row_last", 64'(b_out_last), 64'(mon_eb.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_pix      = 8'h00;
        out_ready   = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_pix    = 8'h00;
        b_out_ready = 1'b0;
        ls_vec      = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h7F};

        #2;
        chk_reset_outputs("rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // row capture
        out_ready = 1'b1;
        q_a.push_back(mk(64'h0706050403020100, 0));
        for (int i = 0; i < 8; i++) send(8'(i));
        chk("cap_valid", 64'(out_valid), 64'd1);
        chk("cap_row", out_row, 64'h0706050403020100);
        chk("cap_idx", 64'(out_row_idx), 64'd0);
        wait_drain("cap");

        // level shift: 80,FF,00,7F -> 00,7F,80,FF
        b_out_ready = 1'b1;
        q_b.push_back(mk(64'hFF807F00FF807F00, 0));
        for (int k = 0; k < 8; k++) begin
            b_in_pix   = ls_vec[k];
            b_in_valid = 1'b1;
            chk("ls_in_ready", 64'(b_in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        chk("ls_valid", 64'(b_out_valid), 64'd1);
        for (int c = 0; c < 10 && q_b.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("ls_drain_left", 64'(q_b.size()), 64'd0);

        // backpressure: both banks fill, third row held off
        do_reset();
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        q_a.push_back(mk(seq_row(8'h10), 0));
        q_a.push_back(mk(seq_row(8'h18), 1));
        q_a.push_back(mk(seq_row(8'h20), 2));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_row0", out_row, seq_row(8'h10));
        in_pix   = 8'h20;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_row", out_row, seq_row(8'h10));
            chk("bp_hold_idx", 64'(out_row_idx), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_row1", out_row, seq_row(8'h18));
        chk("bp_row1_idx", 64'(out_row_idx), 64'd1);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        out_ready = 1'b1;
        wait_drain("bp");

        // block tagging: 9 rows, index wraps after 7
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 9; r++) q_a.push_back(mk(seq_row(8'(r * 8)), r % 8));
        for (int i = 0; i < 72; i++) send(8'(i));
        wait_drain("blk");

        // simultaneous accept + transfer, then flush against both
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        q_a.push_back(mk(seq_row(8'h30), 0));
        for (int i = 0; i < 7; i++) send(8'h40 + 8'(i));
        out_ready = 1'b1;
        send(8'h47);
        chk("sim_valid", 64'(out_valid), 64'd1);
        chk("sim_row1", out_row, seq_row(8'h40));
        chk("sim_idx", 64'(out_row_idx), 64'd1);
        chk("sim_q_left", 64'(q_a.size()), 64'd0);
        flush    = 1'b1;
        in_pix   = 8'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_idx", 64'(out_row_idx), 64'd0);
        q_a.push_back(mk(seq_row(8'h60), 0));
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i));
        wait_drain("fl");

        // async reset in the middle of a row
        for (int i = 0; i < 5; i++) send(8'h70 + 8'(i));
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q_a.push_back(mk(seq_row(8'h80), 0));
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i));
        wait_drain("arst");
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_extra_row", 64'(out_valid), 64'd0);
        chk("ls_q_final", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
